// File: rtl/bc_pkg.sv
// bc_pkg: shared types and constants for the Bulls & Cows guess entry path.
// Contents:
//   DIGIT_W, NUM_DIGITS, MAX_DIGIT, GUESS_W - guess geometry
//   entry_state_t                           - guess entry FSM states
package bc_pkg;
    localparam int DIGIT_W = 4;
    localparam int NUM_DIGITS = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    localparam int GUESS_W = 16;
    typedef enum logic [0:0] {ENTRY, SEND} entry_state_t;
endpackage

// File: rtl/guess_entry_button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect one raw push button.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   raw          - raw asynchronous button level
//   press        - 1-cycle pulse per debounced press, DEBOUNCE_CYCLES+2 cycles after a clean rising edge
module button_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);
    logic        sync1_q, sync2_q, stable_q, stable_d, press_q;
    logic [15:0] cnt_q, cnt_d;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive
    // synchronized samples that disagree with it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q)
            cnt_d = '0;
        else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= stable_d & ~stable_q;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/guess_entry.sv
// guess_entry: collect four BCD digits from buttons/switches and hand the guess to the game FSM.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   digit_in      - switch value of the digit being entered
//   btn_digit     - raw "enter digit" button
//   btn_submit    - raw "submit guess" button
//   btn_clear     - raw "clear entry" button
//   accept        - game FSM takes the guess while confirm is high
//   guess         - assembled BCD guess, first digit in [15:12]
//   confirm       - guess valid, held until accepted
//   digit_count   - digits entered so far (0..4)
//   entry_error   - sticky invalid-action flag
//   busy          - high while a guess awaits acceptance
// Build option: define BC_UNIQUE_DIGITS_EN to reject digits already present in the entry.
module guess_entry
    import bc_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_DIGITS      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               btn_digit,
    input  logic               btn_submit,
    input  logic               btn_clear,
    input  logic               accept,
    output logic [GUESS_W-1:0] guess,
    output logic               confirm,
    output logic [2:0]         digit_count,
    output logic               entry_error,
    output logic               busy
);
    if (NUM_DIGITS != bc_pkg::NUM_DIGITS) begin : g_num_digits_check
        $error("NUM_DIGITS must match bc_pkg::NUM_DIGITS");
    end

    logic               dig_p, sub_p, clr_p, dup, digit_ok;
    entry_state_t       state_q;
    logic [GUESS_W-1:0] guess_q;
    logic [2:0]         count_q;
    logic               error_q, confirm_q, busy_q;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_digit (
        .clock(clock), .reset(reset), .raw(btn_digit), .press(dig_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_submit (
        .clock(clock), .reset(reset), .raw(btn_submit), .press(sub_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clock(clock), .reset(reset), .raw(btn_clear), .press(clr_p)
    );

`ifdef BC_UNIQUE_DIGITS_EN
    // Entered digits sit in the low count_q nibbles because entry shifts left.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < bc_pkg::NUM_DIGITS; i++)
            if (3'(i) < count_q && guess_q[i*DIGIT_W +: DIGIT_W] == digit_in)
                dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    assign digit_ok = digit_in <= MAX_DIGIT && count_q < 3'(bc_pkg::NUM_DIGITS) && !dup;

    // Press priority within a cycle: clear, then submit, then digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ENTRY;
            guess_q   <= '0;
            count_q   <= '0;
            error_q   <= 1'b0;
            confirm_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (clr_p) begin
                        guess_q <= '0;
                        count_q <= '0;
                        error_q <= 1'b0;
                    end else if (sub_p) begin
                        if (count_q == 3'(bc_pkg::NUM_DIGITS)) begin
                            state_q   <= SEND;
                            confirm_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else
                            error_q <= 1'b1;
                    end else if (dig_p) begin
                        if (digit_ok) begin
                            guess_q <= {guess_q[GUESS_W-DIGIT_W-1:0], digit_in};
                            count_q <= count_q + 3'd1;
                            error_q <= 1'b0;
                        end else
                            error_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        state_q   <= ENTRY;
                        guess_q   <= '0;
                        count_q   <= '0;
                        error_q   <= 1'b0;
                        confirm_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign guess       = guess_q;
    assign confirm     = confirm_q;
    assign digit_count = count_q;
    assign entry_error = error_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed self-checking bench for guess_entry with DEBOUNCE_CYCLES=4.
module tb_guess_entry;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        btn_digit = 1'b0, btn_submit = 1'b0, btn_clear = 1'b0, accept = 1'b0;
    logic [15:0] guess;
    logic        confirm, entry_error, busy;
    logic [2:0]  digit_count;
    int          passed = 0, total = 0;

    guess_entry #(.DEBOUNCE_CYCLES(16'd4), .NUM_DIGITS(4)) dut (
        .clock(clock), .reset(reset), .digit_in(digit_in),
        .btn_digit(btn_digit), .btn_submit(btn_submit), .btn_clear(btn_clear),
        .accept(accept), .guess(guess), .confirm(confirm),
        .digit_count(digit_count), .entry_error(entry_error), .busy(busy)
    );

    always #5 clock = ~clock;

    // b: 0 digit, 1 submit, 2 clear. Clean 10-cycle press then settle time.
    task automatic press(input int b, input logic [3:0] d);
        @(negedge clock);
        digit_in = d;
        if (b == 0) btn_digit = 1'b1;
        else if (b == 1) btn_submit = 1'b1;
        else btn_clear = 1'b1;
        repeat (10) @(negedge clock);
        btn_digit = 1'b0; btn_submit = 1'b0; btn_clear = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic check_out(input string name, input logic [15:0] g, input logic [2:0] c,
                             input logic e, input logic cf);
        total++;
        if (guess !== g || digit_count !== c || entry_error !== e || confirm !== cf || busy !== cf)
            $display("FAIL %s: got guess=%h count=%0d err=%b confirm=%b busy=%b, want guess=%h count=%0d err=%b confirm=%b busy=%b",
                     name, guess, digit_count, entry_error, confirm, busy, g, c, e, cf, cf);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        check_out("reset_hold", 16'h0000, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_out("after_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_debounce();
        // 3-cycle glitch must not register.
        @(negedge clock);
        digit_in = 4'd9; btn_digit = 1'b1;
        repeat (3) @(negedge clock);
        btn_digit = 1'b0;
        repeat (15) @(negedge clock);
        check_out("glitch", 16'h0000, 3'd0, 1'b0, 1'b0);
        // Clean press: pulse 6 cycles after edge, state updates on the 7th edge.
        @(negedge clock);
        digit_in = 4'd1; btn_digit = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (digit_count !== 3'd0) $display("FAIL latency_early: count=%0d want 0", digit_count);
        else passed++;
        @(posedge clock);
        #1;
        total++;
        if (digit_count !== 3'd1 || guess !== 16'h0001)
            $display("FAIL latency_edge: count=%0d guess=%h want 1 0001", digit_count, guess);
        else passed++;
        repeat (5) @(negedge clock);
        btn_digit = 1'b0;
        repeat (10) @(negedge clock);
        check_out("held_no_repeat", 16'h0001, 3'd1, 1'b0, 1'b0);
    endtask

    task automatic test_entry_submit();
        press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
        check_out("four_digits", 16'h1234, 3'd4, 1'b0, 1'b0);
        press(1, 4'd0);
        check_out("submitted", 16'h1234, 3'd4, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        check_out("confirm_held", 16'h1234, 3'd4, 1'b0, 1'b1);
        accept = 1'b1;
        @(posedge clock);
        #1;
        check_out("accepted", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        accept = 1'b0;
    endtask

    task automatic test_invalid();
        press(0, 4'd5); press(0, 4'd6); press(0, 4'hA);
        check_out("bad_digit", 16'h0056, 3'd2, 1'b1, 1'b0);
        press(1, 4'd0);
        check_out("early_submit", 16'h0056, 3'd2, 1'b1, 1'b0);
        press(0, 4'd7);
        check_out("error_cleared", 16'h0567, 3'd3, 1'b0, 1'b0);
        press(2, 4'd0);
        check_out("clear1", 16'h0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        press(0, 4'd9); press(0, 4'd8); press(0, 4'd7); press(0, 4'd6); press(0, 4'd5);
        check_out("fifth_digit", 16'h9876, 3'd4, 1'b1, 1'b0);
        press(2, 4'd0);
        check_out("clear2", 16'h0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_send_lock();
        press(0, 4'd4); press(0, 4'd3); press(0, 4'd2); press(0, 4'd1);
        press(1, 4'd0);
        check_out("send_4321", 16'h4321, 3'd4, 1'b0, 1'b1);
        press(2, 4'd0);
        press(0, 4'd8);
        check_out("send_locked", 16'h4321, 3'd4, 1'b0, 1'b1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_out("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int hi;
        accept = 1'b1;
        press(0, 4'd1);
        check_out("accept_in_entry", 16'h0001, 3'd1, 1'b0, 1'b0);
        press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
        @(negedge clock);
        btn_submit = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (confirm === 1'b1) hi++;
        end
        btn_submit = 1'b0;
        total++;
        if (hi !== 1) $display("FAIL confirm_one_cycle: high %0d cycles want 1", hi);
        else passed++;
        accept = 1'b0;
        repeat (10) @(negedge clock);
        check_out("after_quick_xfer", 16'h0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_repeat();
        press(0, 4'd3); press(0, 4'd3);
`ifdef BC_UNIQUE_DIGITS_EN
        check_out("repeat_digit", 16'h0003, 3'd1, 1'b1, 1'b0);
`else
        check_out("repeat_digit", 16'h0033, 3'd2, 1'b0, 1'b0);
`endif
        press(2, 4'd0);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_entry_submit();
        test_invalid();
        test_overflow();
        test_send_lock();
        test_back_to_back();
        test_repeat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
